// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and link-rate divider for the joystick serial link
package serial_pkg;
  typedef enum logic [1:0] {IDLE, BURST, TAIL, FREE} state_t;
  localparam int DEF_DIV = 90;
endpackage

// File: rtl/sclk_halfper_cnt.sv
// sclk_halfper_cnt: half-period counter counting 0..div_q, tick on the wrap cycle
module sclk_halfper_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] div_q,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = enable && !clear && cnt == div_q;
  // count while enabled, restart from zero on clear or wrap
  always_ff @(posedge CLK)
    if (RST || clear || tick) cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
endmodule

// File: rtl/serial_clk_gen.sv
// serial_clk_gen: programmable SCLK generator with bounded bursts or free-running mode and edge strobes
module serial_clk_gen
  import serial_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int NB_W        = 6,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter bit CPOL        = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD_DIV,
  input  logic             START,
  input  logic [NB_W-1:0]  NBITS,
  input  logic             FREE_RUN,
  output logic             SCLK,
  output logic             LEAD_STB,
  output logic             TRAIL_STB,
  output logic             BUSY,
  output logic             DONE
);
  state_t state, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NB_W-1:0] bits, bits_d;
  logic sclk_d, lead_d, trail_d, busy_d, done_d, tick;
  sclk_halfper_cnt #(.W(DIV_W)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .div_q  (div_q),
    .tick   (tick)
  );
  // next state: toggle SCLK at each wrap, count trailing edges in a burst, hold one extra half period in TAIL
  always_comb begin
    state_d = state;
    div_d   = div_q;
    bits_d  = bits;
    sclk_d  = SCLK;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = BUSY;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD_DIV) div_d = DIV;
        if (FREE_RUN) state_d = FREE;
        else if (START && NBITS != '0) begin
          bits_d  = NBITS;
          busy_d  = 1'b1;
          state_d = BURST;
        end
      end
      BURST, FREE: if (tick) begin
        sclk_d  = ~SCLK;
        lead_d  = SCLK == CPOL;
        trail_d = SCLK != CPOL;
        if (trail_d && state == BURST) begin
          bits_d = bits - NB_W'(1);
          if (bits == NB_W'(1)) state_d = TAIL;
        end
        if (trail_d && state == FREE && !FREE_RUN) state_d = IDLE;
      end
      TAIL: if (tick) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // register state and all outputs so strobes coincide with the SCLK change
  always_ff @(posedge CLK)
    if (RST) begin
      state     <= IDLE;
      div_q     <= DIV_W'(DEFAULT_DIV);
      bits      <= '0;
      SCLK      <= CPOL;
      LEAD_STB  <= 1'b0;
      TRAIL_STB <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_d;
      div_q     <= div_d;
      bits      <= bits_d;
      SCLK      <= sclk_d;
      LEAD_STB  <= lead_d;
      TRAIL_STB <= trail_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
endmodule
